pht_ctrl: RTL

PHT_CTRL -- requirements
Module: pht_ctrl

---
 rtl/pht_pkg.sv | 20 ++
 rtl/pht_sat_ctr.sv | 21 ++
 rtl/pht_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pht_pkg.sv
// pht_pkg: shared definitions for the pattern-history-table controller.
//   PHT_ADDR_W / PHT_DATA_W : default table index and counter widths
//   ctr_t                   : 2-bit saturating counter type
//   CTR_WNT                 : weakly-not-taken value written at init
//   state_e                 : controller FSM states
package pht_pkg;
    localparam int PHT_ADDR_W = 4;
    localparam int PHT_DATA_W = 2;

    typedef logic [PHT_DATA_W-1:0] ctr_t;

    localparam ctr_t CTR_WNT = 2'b01;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD,
        WR
    } state_e;
endpackage

// File: rtl/pht_sat_ctr.sv
// pht_sat_ctr: combinational saturating counter step.
//   ctr   in  W  current counter value
//   taken in  1  branch outcome
//   nxt   out W  ctr+1 when taken (stops at all-ones), ctr-1 when not
//                taken (stops at zero); never wraps
module pht_sat_ctr #(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr,
    input  logic         taken,
    output logic [W-1:0] nxt
);
    always_comb begin
        nxt = ctr;
        if (taken && (ctr != '1)) begin
            nxt = ctr + W'(1);
        end else if (!taken && (ctr != '0)) begin
            nxt = ctr - W'(1);
        end
    end
endmodule

// File: rtl/pht_ctrl.sv
// pht_ctrl: branch pattern-history-table controller around a 1R + 1RW SRAM.
//   clk, rst                    : single clock, synchronous active-high reset
//   pred_valid/pred_pc/pred_ready : prediction request; SRAM read on port 0
//   resp_valid/resp_taken/resp_ctr: prediction result one cycle later
//   upd_valid/upd_pc/upd_taken/upd_ready : resolved-branch update, done as a
//                                  read-modify-write on port 1 (IDLE->RD->WR)
//   pht_csb0/web0/addr0/dout0   : SRAM port 0 (read only)
//   pht_csb1/web1/addr1/din1/dout1: SRAM port 1 (update RMW and init fill)
// After reset the controller spends 16 cycles in INIT writing weakly-not-taken
// into every entry; the SRAM itself has no reset.
// Optional macro PHT_GSHARE_EN: index = PC bits XOR a global history register
// that shifts in each accepted update's outcome.
module pht_ctrl
    import pht_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 2,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    output logic                  pred_ready,
    output logic                  resp_valid,
    output logic                  resp_taken,
    output logic [DATA_WIDTH-1:0] resp_ctr,
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_taken,
    output logic                  upd_ready,
    output logic                  pht_csb0,
    output logic                  pht_web0,
    output logic [ADDR_WIDTH-1:0] pht_addr0,
    input  logic [DATA_WIDTH-1:0] pht_dout0,
    output logic                  pht_csb1,
    output logic                  pht_web1,
    output logic [ADDR_WIDTH-1:0] pht_addr1,
    output logic [DATA_WIDTH-1:0] pht_din1,
    input  logic [DATA_WIDTH-1:0] pht_dout1
);
    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pred_idx, upd_idx;
    logic [ADDR_WIDTH-1:0] init_cnt, lat_idx, wb_idx, resp_idx;
    logic                  lat_taken, resp_q;
    logic [DATA_WIDTH-1:0] wb_val, new_ctr;
    logic                  pred_acc, upd_acc;

    // PC bits outside the index field are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:ADDR_WIDTH+2], pred_pc[1:0],
                              upd_pc[PC_WIDTH-1:ADDR_WIDTH+2], upd_pc[1:0]};

`ifdef PHT_GSHARE_EN
    logic [ADDR_WIDTH-1:0] ghr;
    assign pred_idx = pred_pc[ADDR_WIDTH+1:2] ^ ghr;
    assign upd_idx  = upd_pc[ADDR_WIDTH+1:2] ^ ghr;
`else
    assign pred_idx = pred_pc[ADDR_WIDTH+1:2];
    assign upd_idx  = upd_pc[ADDR_WIDTH+1:2];
`endif

    pht_sat_ctr #(.W(DATA_WIDTH)) u_sat (
        .ctr   (pht_dout1),
        .taken (lat_taken),
        .nxt   (new_ctr)
    );

    // rst gates everything combinationally so nothing is issued in the
    // reset cycle itself (e.g. the RD-cycle write of an in-flight update).
    assign pred_ready = !rst && (state != INIT);
    assign upd_ready  = !rst && (state == IDLE);
    assign pred_acc   = pred_valid && pred_ready;
    assign upd_acc    = upd_valid && upd_ready;

    assign pht_web0   = 1'b1;
    assign pht_csb0   = !pred_acc;
    assign pht_addr0  = pred_idx;

    always_comb begin
        state_nxt = state;
        pht_csb1  = 1'b1;
        pht_web1  = 1'b1;
        pht_addr1 = lat_idx;
        pht_din1  = new_ctr;
        if (!rst) begin
            unique case (state)
                INIT: begin
                    pht_csb1  = 1'b0;
                    pht_web1  = 1'b0;
                    pht_addr1 = init_cnt;
                    pht_din1  = DATA_WIDTH'(CTR_WNT);
                    if (init_cnt == '1) state_nxt = IDLE;
                end
                IDLE: begin
                    if (upd_valid) begin
                        pht_csb1  = 1'b0;
                        pht_addr1 = upd_idx;
                        state_nxt = RD;
                    end
                end
                RD: begin
                    pht_csb1  = 1'b0;
                    pht_web1  = 1'b0;
                    state_nxt = WR;
                end
                WR: state_nxt = IDLE;
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            resp_q    <= 1'b0;
            resp_idx  <= '0;
            lat_idx   <= '0;
            lat_taken <= 1'b0;
            wb_idx    <= '0;
            wb_val    <= '0;
`ifdef PHT_GSHARE_EN
            ghr       <= '0;
`endif
        end else begin
            state  <= state_nxt;
            resp_q <= pred_acc;
            if (state == INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
            if (pred_acc) resp_idx <= pred_idx;
            if (upd_acc) begin
                lat_idx   <= upd_idx;
                lat_taken <= upd_taken;
`ifdef PHT_GSHARE_EN
                ghr       <= {ghr[ADDR_WIDTH-2:0], upd_taken};
`endif
            end
            // The write issued in RD only lands in the array at the end of
            // WR, so a read issued in RD needs the value from here.
            if (state == RD) begin
                wb_idx <= lat_idx;
                wb_val <= new_ctr;
            end
        end
    end

    assign resp_valid = resp_q && !rst;
    assign resp_ctr   = ((state == WR) && (resp_idx == wb_idx)) ? wb_val : pht_dout0;
    assign resp_taken = resp_ctr[DATA_WIDTH-1];
endmodule
